regfile_write_scheduler: RTL and testbench



---
 rtl/regfile_write_scheduler_if.sv | 48 ++++
 rtl/regfile_write_scheduler.sv | 101 ++++++++++
 tb/tb_regfile_write_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_scheduler_if.sv
// Signal bundle between WB stage, long-latency unit, decode hazard logic and
// the register-file write port of regfile_write_scheduler.
interface regfile_write_scheduler_if;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        llu_issue_i;
  logic [4:0]  llu_issue_rd_i;
  logic        llu_issue_ready_o;
  logic        llu_res_valid_i;
  logic [4:0]  llu_res_rd_i;
  logic [31:0] llu_res_data_i;
  logic        llu_res_ready_o;
  logic [4:0]  rs1_label_i;
  logic [4:0]  rs2_label_i;
  logic [4:0]  rd_label_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        rd_busy_o;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic        drain_stall_o;

  modport slave (
    input  wb_we_i, wb_rd_i, wb_data_i,
    input  llu_issue_i, llu_issue_rd_i,
    output llu_issue_ready_o,
    input  llu_res_valid_i, llu_res_rd_i, llu_res_data_i,
    output llu_res_ready_o,
    input  rs1_label_i, rs2_label_i, rd_label_i,
    output rs1_busy_o, rs2_busy_o, rd_busy_o,
    output rf_we_o, rf_rd_o, rf_data_o,
    output drain_stall_o
  );

  modport master (
    output wb_we_i, wb_rd_i, wb_data_i,
    output llu_issue_i, llu_issue_rd_i,
    input  llu_issue_ready_o,
    output llu_res_valid_i, llu_res_rd_i, llu_res_data_i,
    input  llu_res_ready_o,
    output rs1_label_i, rs2_label_i, rd_label_i,
    input  rs1_busy_o, rs2_busy_o, rd_busy_o,
    input  rf_we_o, rf_rd_o, rf_data_o,
    input  drain_stall_o
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between the WB stage and a
// queue of long-latency results, and tracks pending destinations for decode.
module regfile_write_scheduler #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                        clk_i,
  input logic                        rst_i,
  regfile_write_scheduler_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [31:0]      busy_q, busy_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             drain_q, drain_d;

  logic empty, full, wb_claim, pop, push, issue_accept;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    wb_claim     = bus.wb_we_i && (bus.wb_rd_i != 5'd0);
    pop          = !wb_claim && !empty;
    // Readiness comes from registered fullness only, so a same-cycle pop never frees a slot.
    push         = bus.llu_res_valid_i && !full && (bus.llu_res_rd_i != 5'd0);
    issue_accept = bus.llu_issue_i && (bus.llu_issue_rd_i != 5'd0)
                   && !busy_q[bus.llu_issue_rd_i];

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    busy_d = busy_q;
    if (pop)
      busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
    if (issue_accept)
      busy_d[bus.llu_issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    starve_d = starve_q;
    if (empty || pop)
      starve_d = '0;
    else if (starve_q != STV_W'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;

    // Once raised, the stall holds until the queue has fully drained.
    drain_d = drain_q;
    if (count_d == '0)
      drain_d = 1'b0;
    else if (starve_d == STV_W'(STARVE_LIMIT))
      drain_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      drain_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      drain_q  <= drain_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.llu_res_rd_i;
      fifo_data_q[wr_ptr_q] <= bus.llu_res_data_i;
    end
  end

  assign bus.rf_we_o           = wb_claim || !empty;
  assign bus.rf_rd_o           = wb_claim ? bus.wb_rd_i   : fifo_rd_q[rd_ptr_q];
  assign bus.rf_data_o         = wb_claim ? bus.wb_data_i : fifo_data_q[rd_ptr_q];
  assign bus.llu_res_ready_o   = !full;
  assign bus.llu_issue_ready_o = !busy_q[bus.llu_issue_rd_i];
  assign bus.rs1_busy_o        = busy_q[bus.rs1_label_i];
  assign bus.rs2_busy_o        = busy_q[bus.rs2_label_i];
  assign bus.rd_busy_o         = busy_q[bus.rd_label_i];
  assign bus.drain_stall_o     = drain_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: stimulus queues expected writes
// and per-cycle status values; a negedge monitor pops and compares them.
module tb_regfile_write_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_scheduler_if ifc ();

  regfile_write_scheduler #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  typedef enum int {S_RF_WE, S_RF_RD, S_RS1, S_RS2, S_RDB,
                    S_ISSUE_RDY, S_RES_RDY, S_DRAIN} sel_e;
  typedef struct { int at; sel_e sel; logic [31:0] val; } st_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;

  st_t st_q[$];
  wr_t wb_q[$];
  wr_t llu_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(sel_e s);
    case (s)
      S_RF_WE:     return {31'b0, ifc.rf_we_o};
      S_RF_RD:     return {27'b0, ifc.rf_rd_o};
      S_RS1:       return {31'b0, ifc.rs1_busy_o};
      S_RS2:       return {31'b0, ifc.rs2_busy_o};
      S_RDB:       return {31'b0, ifc.rd_busy_o};
      S_ISSUE_RDY: return {31'b0, ifc.llu_issue_ready_o};
      S_RES_RDY:   return {31'b0, ifc.llu_res_ready_o};
      default:     return {31'b0, ifc.drain_stall_o};
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin : monitor
    wr_t e;
    st_t s;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb_q.delete();
        llu_q.delete();
      end else begin
        if (ifc.wb_we_i && ifc.wb_rd_i != 5'd0) begin
          checks++;
          if (wb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_write cyc %0d: no expectation queued", cyc);
          end else begin
            e = wb_q.pop_front();
            if (ifc.rf_we_o !== 1'b1 || ifc.rf_rd_o !== e.rd || ifc.rf_data_o !== e.data) begin
              errors++;
              $display("FAIL wb_write cyc %0d: got we=%0b rd=%0d data=%h, expected we=1 rd=%0d data=%h",
                       cyc, ifc.rf_we_o, ifc.rf_rd_o, ifc.rf_data_o, e.rd, e.data);
            end
          end
        end else if (ifc.rf_we_o === 1'b1) begin
          checks++;
          if (llu_q.size() == 0) begin
            errors++;
            $display("FAIL llu_write cyc %0d: unexpected write rd=%0d data=%h",
                     cyc, ifc.rf_rd_o, ifc.rf_data_o);
          end else begin
            e = llu_q.pop_front();
            if (ifc.rf_rd_o !== e.rd || ifc.rf_data_o !== e.data) begin
              errors++;
              $display("FAIL llu_write cyc %0d: got rd=%0d data=%h, expected rd=%0d data=%h",
                       cyc, ifc.rf_rd_o, ifc.rf_data_o, e.rd, e.data);
            end
          end
        end
        while (st_q.size() > 0 && st_q[0].at <= cyc) begin
          s = st_q.pop_front();
          checks++;
          if (s.at != cyc) begin
            errors++;
            $display("FAIL %s: check for cyc %0d not sampled", s.sel.name(), s.at);
          end else if (actual(s.sel) !== s.val) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0h, expected %0h",
                     s.sel.name(), cyc, actual(s.sel), s.val);
          end
        end
      end
      if (cyc > 3000) begin
        errors++;
        $display("FAIL timeout: cyc %0d, expected done by 3000", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (done) begin
        checks++;
        if (llu_q.size() != 0 || wb_q.size() != 0 || st_q.size() != 0) begin
          errors++;
          $display("FAIL leftover: got llu=%0d wb=%0d st=%0d pending, expected 0",
                   llu_q.size(), wb_q.size(), st_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    ifc.wb_we_i         = 1'b0;
    ifc.wb_rd_i         = '0;
    ifc.wb_data_i       = '0;
    ifc.llu_issue_i     = 1'b0;
    ifc.llu_issue_rd_i  = '0;
    ifc.llu_res_valid_i = 1'b0;
    ifc.llu_res_rd_i    = '0;
    ifc.llu_res_data_i  = '0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    ifc.wb_we_i   = 1'b1;
    ifc.wb_rd_i   = rd;
    ifc.wb_data_i = d;
    if (rd != 5'd0) wb_q.push_back('{rd, d});
  endtask

  task automatic res(input logic [4:0] rd, input logic [31:0] d, input bit acc);
    ifc.llu_res_valid_i = 1'b1;
    ifc.llu_res_rd_i    = rd;
    ifc.llu_res_data_i  = d;
    if (acc && rd != 5'd0) llu_q.push_back('{rd, d});
  endtask

  task automatic issue(input logic [4:0] rd);
    ifc.llu_issue_i    = 1'b1;
    ifc.llu_issue_rd_i = rd;
  endtask

  task automatic labels(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    ifc.rs1_label_i = a;
    ifc.rs2_label_i = b;
    ifc.rd_label_i  = c;
  endtask

  task automatic chk(input sel_e s, input logic [31:0] v);
    st_q.push_back('{cyc, s, v});
  endtask

  initial begin : stimulus
    rst = 1'b1;
    ifc.wb_we_i = 1'b0; ifc.wb_rd_i = '0; ifc.wb_data_i = '0;
    ifc.llu_issue_i = 1'b0; ifc.llu_issue_rd_i = '0;
    ifc.llu_res_valid_i = 1'b0; ifc.llu_res_rd_i = '0; ifc.llu_res_data_i = '0;
    labels(5, 7, 9);
    repeat (2) @(posedge clk);

    // Reset state, then basic issue -> result -> write -> clear
    next_cycle(); rst = 1'b0;
    chk(S_RF_WE, 0); chk(S_RS1, 0); chk(S_RS2, 0); chk(S_RDB, 0);
    chk(S_RES_RDY, 1); chk(S_DRAIN, 0);
    issue(5); chk(S_ISSUE_RDY, 1);
    next_cycle(); chk(S_RS1, 1); res(5, 32'hDEADBEEF, 1); chk(S_RES_RDY, 1); chk(S_RF_WE, 0);
    next_cycle(); chk(S_RF_WE, 1); chk(S_RF_RD, 5); chk(S_RS1, 1);
    next_cycle(); chk(S_RS1, 0); chk(S_RF_WE, 0);

    // WB has priority over a pending head; x0 write does not claim the port
    next_cycle(); issue(7); chk(S_RS2, 0);
    next_cycle(); res(7, 32'h77, 1); chk(S_RS2, 1);
    next_cycle(); wb(3, 32'h11); chk(S_RF_RD, 3); chk(S_RS2, 1);
    next_cycle(); wb(4, 32'h44); chk(S_RS2, 1);
    next_cycle(); wb(0, 32'hFFFF); chk(S_RF_WE, 1); chk(S_RF_RD, 7); chk(S_RS2, 1);
    next_cycle(); chk(S_RS2, 0); chk(S_RF_WE, 0);

    // Fill under continuous WB traffic, starvation raises drain stall
    next_cycle(); wb(1, 32'h100); res(10, 32'hA0, 1);
    next_cycle(); wb(1, 32'h101); res(11, 32'hB1, 1); chk(S_RES_RDY, 1);
    next_cycle(); wb(1, 32'h102); chk(S_RES_RDY, 0); chk(S_DRAIN, 0);
    next_cycle(); wb(1, 32'h103); chk(S_DRAIN, 0);
    next_cycle(); wb(1, 32'h104); chk(S_DRAIN, 0); chk(S_RES_RDY, 0);
    next_cycle(); chk(S_DRAIN, 1); chk(S_RF_RD, 10);
    next_cycle(); chk(S_DRAIN, 1); chk(S_RF_RD, 11); chk(S_RES_RDY, 1);
    next_cycle(); chk(S_DRAIN, 0); chk(S_RF_WE, 0);

    // Issue to a busy register is refused; rd = 0 issue/result are no-ops
    next_cycle(); issue(9); chk(S_ISSUE_RDY, 1); chk(S_RDB, 0);
    next_cycle(); issue(9); chk(S_ISSUE_RDY, 0); chk(S_RDB, 1);
    next_cycle(); issue(0); res(0, 32'hBAD, 1); chk(S_ISSUE_RDY, 1); chk(S_RES_RDY, 1);
    next_cycle(); labels(0, 0, 9); chk(S_RF_WE, 0); chk(S_RS1, 0); chk(S_RDB, 1);
    next_cycle(); res(9, 32'h99, 1); chk(S_RDB, 1);
    next_cycle(); chk(S_RF_RD, 9); chk(S_RDB, 1);
    next_cycle(); labels(5, 7, 9); chk(S_RDB, 0);

    // Reset mid-operation discards queued results and busy bits
    next_cycle(); issue(5);
    next_cycle(); issue(7); wb(2, 32'h20);
    next_cycle(); res(5, 32'h55, 1); wb(2, 32'h21);
    next_cycle(); res(7, 32'h57, 1); wb(2, 32'h22);
    next_cycle(); wb(2, 32'h23); chk(S_RES_RDY, 0); chk(S_RS1, 1); chk(S_RS2, 1);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    chk(S_RS1, 0); chk(S_RS2, 0); chk(S_RDB, 0);
    chk(S_RF_WE, 0); chk(S_DRAIN, 0); chk(S_RES_RDY, 1);

    // Full-cycle pop does not admit a push; pointer wrap over 5 results
    next_cycle(); wb(1, 32'h200); res(12, 32'hC0, 1);
    next_cycle(); wb(1, 32'h201); res(13, 32'hC1, 1); chk(S_RES_RDY, 1);
    next_cycle(); res(14, 32'hC2, 0); chk(S_RES_RDY, 0); chk(S_RF_RD, 12);
    next_cycle(); res(14, 32'hC2, 1); chk(S_RES_RDY, 1); chk(S_RF_RD, 13);
    next_cycle(); res(15, 32'hC3, 1); chk(S_RF_RD, 14);
    next_cycle(); res(16, 32'hC4, 1); chk(S_RF_RD, 15);
    next_cycle(); chk(S_RF_RD, 16);
    next_cycle(); chk(S_RF_WE, 0);

    next_cycle();
    next_cycle();
    done = 1'b1;
  end

endmodule
